// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scanner; optional SEG_SCAN_LZ_BLANK_EN adds leading-zero suppression
module seg_scan_ctrl #(
    parameter  int DIGITS      = 4,
    parameter  int REFRESH_DIV = 100000,
    localparam int SEL_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [SEL_W-1:0]      digit_sel,
    output logic                  tick
);

    localparam int              PRESC_W    = $clog2(REFRESH_DIV + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(DIGITS - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               tick_q, tick_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [DIGITS-1:0]  lz_blank;

    // Active-low cathode pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic zero_above;

    // Digit i (i >= 1) goes dark when it and every more significant nibble are zero.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (digit_data[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Next-state scan position and the pin image for the digit about to be lit.
    always_comb begin
        presc_d = presc_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        an_d    = '1;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            // Outputs follow sel_d so anode and cathode change on the same edge.
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_d == SEL_W'(i)) begin
                    an_d[i] = 1'b0;
                    if (!(blank_mask[i] || lz_blank[i])) begin
                        seg_d = hex7(digit_data[4*i +: 4]);
                        dp_d  = ~dp_in[i];
                    end
                end
            end
        end
    end

    // State and registered pins; reset drops the display dark immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sel_q   <= '0;
            tick_q  <= 1'b0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_sel = sel_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl with a cycle-level reference model
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int RD     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digit_data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
        logic       tick;
    } out_t;

    out_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_pre = 0;
    int   m_dig = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seg_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Reference: what the pins show after the coming clock edge, given current inputs.
    function automatic out_t model_edge();
        out_t       o;
        logic       blank;
        logic [3:0] nib;
        o.an   = 4'hF;
        o.seg  = 7'h7F;
        o.dp   = 1'b1;
        o.tick = 1'b0;
        if (!rst_n) begin
            m_pre = 0;
            m_dig = 0;
            o.sel = 2'd0;
            return o;
        end
        if (en) begin
            m_pre = m_pre + 1;
            if (m_pre == RD) begin
                m_pre  = 0;
                m_dig  = (m_dig + 1) % DIGITS;
                o.tick = 1'b1;
            end
            o.an  = ~(4'b0001 << m_dig);
            nib   = 4'((digit_data >> (4 * m_dig)) & 16'hF);
            blank = blank_mask[m_dig];
`ifdef SEG_SCAN_LZ_BLANK_EN
            if (m_dig >= 1 && (digit_data >> (4 * m_dig)) == 16'h0) blank = 1'b1;
`endif
            if (!blank) begin
                o.seg = seg_tab[nib];
                o.dp  = ~dp_in[m_dig];
            end
        end
        o.sel = 2'(m_dig);
        return o;
    endfunction

    // One cycle of stimulus: inputs change just after the falling edge.
    task automatic step(input logic r, input logic e, input logic [15:0] dd,
                        input logic [3:0] dpi, input logic [3:0] bm);
        @(negedge clk);
        #1;
        rst_n      = r;
        en         = e;
        digit_data = dd;
        dp_in      = dpi;
        blank_mask = bm;
        if (!r) begin
            #1;
            vectors++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || tick !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset_dark: got an=%b seg=%h dp=%b tick=%b, want an=1111 seg=7f dp=1 tick=0",
                         an, seg, dp, tick);
            end
        end
        exp_q.push_back(model_edge());
    endtask

    // Monitor: each falling edge compares pins against the oldest expectation.
    initial begin
        out_t e;
        out_t g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{an: an, seg: seg, dp: dp, sel: digit_sel, tick: tick};
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL pins @%0t: got an=%b seg=%b dp=%b sel=%0d tick=%b, want an=%b seg=%b dp=%b sel=%0d tick=%b",
                             $time, g.an, g.seg, g.dp, g.sel, g.tick, e.an, e.seg, e.dp, e.sel, e.tick);
                end
            end
        end
    end

    task automatic bound_check(input bit ok, input string name);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: scan position not reached, got dig=%0d pre=%0d", name, m_dig, m_pre);
        end
    endtask

    initial begin
        logic [15:0] dd;
        logic        r;

        // Reset and first scan with the decode pattern.
        step(1'b0, 1'b0, 16'hA980, 4'b0010, 4'b0000);
        step(1'b0, 1'b0, 16'hA980, 4'b0010, 4'b0000);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'hA980, 4'b0010, 4'b0000);

        // Enable gating in the middle of digit 2.
        for (int i = 0; i < 40 && !(m_dig == 2 && m_pre == 1); i++)
            step(1'b1, 1'b1, 16'hA980, 4'b0010, 4'b0000);
        bound_check(m_dig == 2 && m_pre == 1, "reach_digit2");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'hA980, 4'b0010, 4'b0000);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 16'hA980, 4'b0010, 4'b0000);

        // Blank mask on digit 3 with its decimal point requested.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 16'h1234, 4'b1000, 4'b1000);

        // Asynchronous reset in the middle of digit 3.
        for (int i = 0; i < 40 && !(m_dig == 3 && m_pre == 2); i++)
            step(1'b1, 1'b1, 16'h5678, 4'b0101, 4'b0000);
        bound_check(m_dig == 3 && m_pre == 2, "reach_digit3");
        step(1'b0, 1'b1, 16'h5678, 4'b0101, 4'b0000);
        step(1'b0, 1'b1, 16'h5678, 4'b0101, 4'b0000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'h5678, 4'b0101, 4'b0000);

        // Leading-zero patterns.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 16'h0070, 4'b1111, 4'b0000);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 16'h0000, 4'b0000, 4'b0000);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            dd = 16'($urandom);
            dd = dd >> (4 * $urandom_range(0, 4));
            r  = ($urandom_range(0, 99) != 0);
            step(r, ($urandom_range(0, 7) != 0), dd, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display scanner. It is the successor to the fixed 4-digit anode decoder.
- Owns its own refresh prescaler and digit counter, so no external SEL is needed.
- Generates active-low anodes for N digits.
- Decodes each digit's hex nibble to active-low cathodes, including per-digit decimal point and blanking.
- Sits between datapath registers (BCD/hex values) and the Basys3 an/seg/dp pins.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8.
REFRESH_DIV, 100000, clock cycles each digit stays lit; legal range >=1. Default gives 1 kHz per digit at 100 MHz.
SEL_W, (DIGITS>1 ? $clog2(DIGITS) : 1), width of digit_sel; derived, never overridden.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active low
en  input  1  scan enable; low blanks the display and freezes the scan
digit_data  input  4*DIGITS  hex nibble per digit; digit i = digit_data[4i+3:4i]
dp_in  input  DIGITS  decimal point request per digit, active high
blank_mask  input  DIGITS  1 = force digit i dark
an  output  DIGITS  anodes, active low, registered
seg  output  7  cathodes {g,f,e,d,c,b,a}, active low, registered
dp  output  1  decimal point cathode, active low, registered
digit_sel  output  SEL_W  index of the digit currently driven, registered
tick  output  1  one-cycle pulse on each digit advance, registered

Behaviour:
Clock and reset:
- One clock (clk).
- Reset is asynchronous and active-low (rst_n). All state clears immediately on rst_n low, independent of clk.

Reset values:
- prescaler = 0, digit_sel = 0, tick = 0.
- an = all ones, seg = 7'h7F, dp = 1 (display dark).

Prescaler:
- Counts 0..REFRESH_DIV-1 while en = 1, then wraps to 0.
- Width is $clog2(REFRESH_DIV+1).
- REFRESH_DIV = 1 advances every cycle.

Digit advance:
- Occurs on the edge where prescaler == REFRESH_DIV-1 and en = 1.
- digit_sel increments; DIGITS-1 wraps to 0. Non-power-of-two DIGITS never reaches an illegal index.
- tick = 1 for exactly that cycle; otherwise 0.
- DIGITS = 1: digit_sel stays 0 and tick still pulses.

Output register:
- Every edge with en = 1, outputs are computed from the next-state digit index k:
  - an = ~(1<<k).
  - seg = hex decode of nibble k.
  - dp = ~dp_in[k].
- an, seg, dp and digit_sel therefore always change on the same edge, so there is no anode/cathode skew.
- Latency from a digit_data, dp_in or blank_mask change to the pins is 1 cycle.

Blanking:
- If blank_mask[k] = 1: an[k] still asserts, but seg = 7'h7F and dp = 1.
- This keeps the scan duty constant.

Hex decode (seg, active low):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
- 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
- C = 1000110, d = 0100001, E = 0000110, F = 0001110

en low:
- Prescaler and digit_sel hold.
- tick = 0, an = all ones, seg = 7'h7F, dp = 1.

en rising:
- Scanning resumes on the held digit with the held prescaler value; no skipped or doubled digit.

Reset mid-scan:
- Outputs go dark immediately.
- After release, the first enabled edge lights digit 0 with prescaler = 1.

Optional Feature:
Macro: SEG_SCAN_LZ_BLANK_EN
- Defined: leading-zero suppression.
  - Digit k (k >= 1) is blanked when its nibble and every higher digit's nibble are 0.
  - Digit 0 is never auto-blanked, so value 0 shows "0".
  - Auto-blanking is ORed with blank_mask.
  - Decimal point is also suppressed on auto-blanked digits.
- Not defined: no suppression; only blank_mask blanks digits. No extra logic is compiled.

Test Plan:
Bench settings: DIGITS = 4, REFRESH_DIV = 4, en = 1 unless stated.
1. Reset/first scan: release rst_n -> outputs dark until the first edge; then an = 1110, digit_sel = 0. Advance after 4 cycles to an = 1101; digit_sel sequence 0,1,2,3,0; tick pulses every 4th cycle.
2. Decode: digit_data = 16'hA980, dp_in = 4'b0010 -> seg = 1000000 (digit 0), 0000000 with dp = 0 (digit 1), 0010000 (digit 2), 0001000 (digit 3).
3. Enable gating: drop en for 10 cycles mid-digit 2 -> an = 1111, seg = 7F, tick = 0. Re-assert en -> digit 2 completes its remaining count, then moves to digit 3.
4. Blank mask: blank_mask = 4'b1000 with dp_in[3] = 1 -> during digit 3, an = 0111, seg = 7F, dp = 1.
5. Async reset mid-digit 3: pulse rst_n low between edges -> an = 1111 immediately; digit_sel = 0 after release.
6. SEG_SCAN_LZ_BLANK_EN defined:
   - digit_data = 16'h0070 -> digits 3 and 2 dark, digit 1 = 7, digit 0 = 0.
   - digit_data = 16'h0000 -> only digit 0 lit, showing "0".
   - Undefined -> all four digits lit.
